// File: rtl/crack_scheduler_if.sv
// rtl/crack_scheduler_if.sv - host and crack-core handshake bundle for crack_scheduler
interface crack_scheduler_if #(
  parameter int NUM_CORES = 2,
  parameter int KEY_W     = 24
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  // host side
  logic                       en;
  logic                       rdy;
  logic                       busy;
  logic                       key_valid;
  logic [KEY_W-1:0]           key_out;
  logic [IDX_W-1:0]           win_core;

  // crack-core side
  logic [NUM_CORES-1:0]       core_rdy;
  logic [NUM_CORES-1:0]       core_en;
  logic [NUM_CORES*KEY_W-1:0] core_base;
  logic [NUM_CORES*KEY_W-1:0] core_last;
  logic [NUM_CORES-1:0]       core_done;
  logic [NUM_CORES-1:0]       core_hit;
  logic [NUM_CORES*KEY_W-1:0] core_key;
  logic [NUM_CORES-1:0]       core_abort;

  modport slave (
    input  en, core_rdy, core_done, core_hit, core_key,
    output rdy, busy, key_valid, key_out, win_core,
           core_en, core_base, core_last, core_abort
  );

  modport master (
    output en, core_rdy, core_done, core_hit, core_key,
    input  rdy, busy, key_valid, key_out, win_core,
           core_en, core_base, core_last, core_abort
  );
endinterface

// File: rtl/crack_scheduler.sv
// rtl/crack_scheduler.sv - ARC4 key-chunk dispatcher over NUM_CORES crack cores (optional CRACK_SCHED_PERF_EN counters)
module crack_scheduler #(
  parameter int NUM_CORES = 2,
  parameter int KEY_W     = 24,
  parameter int CHUNK_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  crack_scheduler_if.slave  bus
`ifdef CRACK_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [15:0]       perf_chunks
`endif
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [KEY_W:0] ONE      = {{KEY_W{1'b0}}, 1'b1};
  localparam logic [KEY_W:0] CHUNK_SZ = ONE << CHUNK_W;
  localparam logic [KEY_W:0] CHUNK_M1 = CHUNK_SZ - ONE;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  // one extra bit so the chunk after the last one reads as "past the end" instead of 0
  logic [KEY_W:0]       next_base_q, next_base_d;
  logic                 hit_q, hit_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic [NUM_CORES-1:0] assigned_q, assigned_d;
  logic                 abort_pend_q, abort_pend_d;
  logic [KEY_W-1:0]     base_q [NUM_CORES];
  logic [KEY_W-1:0]     base_d [NUM_CORES];
  logic [KEY_W-1:0]     last_q [NUM_CORES];
  logic [KEY_W-1:0]     last_d [NUM_CORES];

  logic                 free_any;
  logic [IDX_W-1:0]     free_idx;
  logic [KEY_W:0]       chunk_end;
  logic [KEY_W-1:0]     chunk_last;
  logic                 do_disp;
  logic                 start;

  logic [NUM_CORES-1:0] done_eff;
  logic                 cand_valid;
  logic [KEY_W-1:0]     cand_key;
  logic [IDX_W-1:0]     cand_idx;
  logic                 accept_hit;

  logic [NUM_CORES-1:0] abort_vec;
  logic [NUM_CORES-1:0] en_vec;
  logic [NUM_CORES*KEY_W-1:0] base_flat;
  logic [NUM_CORES*KEY_W-1:0] last_flat;

  assign start = (state_q != S_RUN) && bus.en;

  // Pick the lowest-index core that is ready and not already holding a chunk
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (bus.core_rdy[i] && !assigned_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Chunk bounds: the final chunk is clipped to the all-ones key
  always_comb begin
    chunk_end  = next_base_q + CHUNK_M1;
    chunk_last = chunk_end[KEY_W] ? {KEY_W{1'b1}} : chunk_end[KEY_W-1:0];
    do_disp    = (state_q == S_RUN) && !hit_q && !next_base_q[KEY_W] && free_any;
  end

  // Smallest key among this cycle's hits, lowest index on ties
  always_comb begin
    done_eff   = (state_q == S_RUN) ? (bus.core_done & assigned_q) : '0;
    cand_valid = 1'b0;
    cand_key   = '0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (done_eff[i] && bus.core_hit[i] &&
          (!cand_valid || (bus.core_key[i*KEY_W +: KEY_W] < cand_key))) begin
        cand_valid = 1'b1;
        cand_key   = bus.core_key[i*KEY_W +: KEY_W];
        cand_idx   = IDX_W'(i);
      end
    end
    accept_hit = cand_valid && (!hit_q || (cand_key < key_q));
  end

  // Abort cores whose whole chunk lies above the recorded key; a same-cycle done wins
  always_comb begin
    abort_vec = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      abort_vec[i] = (state_q == S_RUN) && abort_pend_q && assigned_q[i] &&
                     !bus.core_done[i] && (base_q[i] > key_q);
    end
  end

  // Next-state and dispatch/collection bookkeeping
  always_comb begin
    state_d      = state_q;
    next_base_d  = next_base_q;
    hit_d        = hit_q;
    key_d        = key_q;
    win_d        = win_q;
    assigned_d   = assigned_q;
    abort_pend_d = 1'b0;
    base_d       = base_q;
    last_d       = last_q;
    en_vec       = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.en) begin
          next_base_d = '0;
          hit_d       = 1'b0;
          key_d       = '0;
          win_d       = '0;
          assigned_d  = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        assigned_d = assigned_q & ~done_eff & ~abort_vec;
        if (do_disp) begin
          assigned_d[free_idx] = 1'b1;
          en_vec[free_idx]     = 1'b1;
          base_d[free_idx]     = next_base_q[KEY_W-1:0];
          last_d[free_idx]     = chunk_last;
          next_base_d          = next_base_q + CHUNK_SZ;
        end
        if (accept_hit) begin
          hit_d        = 1'b1;
          key_d        = cand_key;
          win_d        = cand_idx;
          abort_pend_d = 1'b1;
        end
        if ((assigned_d == '0) && (hit_d || next_base_d[KEY_W])) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      next_base_q  <= '0;
      hit_q        <= 1'b0;
      key_q        <= '0;
      win_q        <= '0;
      assigned_q   <= '0;
      abort_pend_q <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        base_q[i] <= '0;
        last_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      next_base_q  <= next_base_d;
      hit_q        <= hit_d;
      key_q        <= key_d;
      win_q        <= win_d;
      assigned_q   <= assigned_d;
      abort_pend_q <= abort_pend_d;
      base_q       <= base_d;
      last_q       <= last_d;
    end
  end

  // Per-core bounds present the new chunk in the dispatch cycle and hold it afterwards
  always_comb begin
    base_flat = '0;
    last_flat = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      base_flat[i*KEY_W +: KEY_W] = base_d[i];
      last_flat[i*KEY_W +: KEY_W] = last_d[i];
    end
  end

  assign bus.rdy        = (state_q != S_RUN);
  assign bus.busy       = (state_q == S_RUN);
  assign bus.key_valid  = (state_q == S_DONE) && hit_q;
  assign bus.key_out    = key_q;
  assign bus.win_core   = win_q;
  assign bus.core_en    = en_vec;
  assign bus.core_base  = base_flat;
  assign bus.core_last  = last_flat;
  assign bus.core_abort = abort_vec;

`ifdef CRACK_SCHED_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [15:0] perf_chunks_q;

  // Search cycle and dispatch counters, cleared on each accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_chunks_q <= '0;
    end else if (start) begin
      perf_cycles_q <= '0;
      perf_chunks_q <= '0;
    end else if (state_q == S_RUN) begin
      if (perf_cycles_q != 32'hFFFF_FFFF) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if (do_disp) begin
        perf_chunks_q <= perf_chunks_q + 16'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_chunks = perf_chunks_q;
`else
  logic unused_start;
  assign unused_start = start;
`endif

endmodule

// File: tb/tb_crack_scheduler.sv
// tb/tb_crack_scheduler.sv - directed self-checking bench for crack_scheduler
module tb_crack_scheduler;
  localparam int NC = 2;
  localparam int KW = 24;
  localparam int CW = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  crack_scheduler_if #(.NUM_CORES(NC), .KEY_W(KW)) bus ();

`ifdef CRACK_SCHED_PERF_EN
  logic [31:0] perf_cycles;
  logic [15:0] perf_chunks;
`endif

  crack_scheduler #(.NUM_CORES(NC), .KEY_W(KW), .CHUNK_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CRACK_SCHED_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_chunks (perf_chunks)
`endif
  );

  int checks = 0;
  int errors = 0;

  // behavioural core models: fixed latency per dispatch, optional forced hit key
  int            lat [NC];
  bit            force_hit [NC];
  logic [KW-1:0] force_key [NC];
  logic [NC-1:0]    m_busy;
  logic [NC-1:0]    m_done;
  logic [NC-1:0]    m_hit;
  logic [NC*KW-1:0] m_key;
  int               m_cnt [NC];

  assign bus.core_rdy  = ~m_busy;
  assign bus.core_done = m_done;
  assign bus.core_hit  = m_hit;
  assign bus.core_key  = m_key;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= '0;
      m_done <= '0;
      m_hit  <= '0;
      m_key  <= '0;
      for (int c = 0; c < NC; c++) m_cnt[c] <= 0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        m_done[c] <= 1'b0;
        if (m_busy[c]) begin
          if (bus.core_abort[c]) begin
            m_busy[c] <= 1'b0;
          end else if (m_cnt[c] <= 1) begin
            m_busy[c]         <= 1'b0;
            m_done[c]         <= 1'b1;
            m_hit[c]          <= force_hit[c];
            m_key[c*KW +: KW] <= force_hit[c] ? force_key[c] : '0;
          end else begin
            m_cnt[c] <= m_cnt[c] - 1;
          end
        end else if (bus.core_en[c]) begin
          m_busy[c] <= 1'b1;
          m_cnt[c]  <= lat[c];
        end
      end
    end
  end

  // monitor: dispatch log, abort counts, last-done and rdy-rise cycle stamps
  int            cyc = 0;
  int            disp_n = 0;
  int            abort_cnt [NC] = '{default: 0};
  int            done_cyc = 0;
  int            rdy_cyc = 0;
  logic          rdy_prev = 1'b1;
  logic [KW-1:0] d_base [64];
  logic [KW-1:0] d_last [64];

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    rdy_prev <= bus.rdy;
    if (bus.rdy && !rdy_prev) rdy_cyc <= cyc;
    if (!rst) begin
      if (|bus.core_done) done_cyc <= cyc;
      for (int c = 0; c < NC; c++) begin
        if (bus.core_en[c] && disp_n < 64) begin
          d_base[disp_n] <= bus.core_base[c*KW +: KW];
          d_last[disp_n] <= bus.core_last[c*KW +: KW];
        end
        if (bus.core_abort[c]) abort_cnt[c] <= abort_cnt[c] + 1;
      end
      if (|bus.core_en) disp_n <= disp_n + 1;
    end
  end

  task automatic pulse_en();
    @(negedge clk);
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
  endtask

  task automatic wait_rdy(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bus.rdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", bus.rdy); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", bus.key_valid); end
    checks++; if (bus.key_out !== 24'h0) begin errors++; $display("FAIL reset_key_out: got %h expected 000000", bus.key_out); end
    checks++; if (bus.win_core !== 1'b0) begin errors++; $display("FAIL reset_win_core: got %h expected 0", bus.win_core); end
    checks++; if (bus.core_en !== 2'b00) begin errors++; $display("FAIL reset_core_en: got %b expected 00", bus.core_en); end
    checks++; if (bus.core_abort !== 2'b00) begin errors++; $display("FAIL reset_core_abort: got %b expected 00", bus.core_abort); end
    checks++; if (bus.core_base !== 48'h0) begin errors++; $display("FAIL reset_core_base: got %h expected 0", bus.core_base); end
    checks++; if (bus.core_last !== 48'h0) begin errors++; $display("FAIL reset_core_last: got %h expected 0", bus.core_last); end
  endtask

  task automatic test_full_miss();
    int d0, a0, a1;
    bit ok;
    lat = '{8, 8};
    force_hit = '{1'b0, 1'b0};
    @(negedge clk);
    d0 = disp_n; a0 = abort_cnt[0]; a1 = abort_cnt[1];
    pulse_en();
    checks++; if (bus.core_en !== 2'b01) begin errors++; $display("FAIL miss_first_en: got %b expected 01", bus.core_en); end
    checks++; if (bus.core_base[23:0] !== 24'h000000) begin errors++; $display("FAIL miss_first_base: got %h expected 000000", bus.core_base[23:0]); end
    checks++; if (bus.core_last[23:0] !== 24'h0FFFFF) begin errors++; $display("FAIL miss_first_last: got %h expected 0fffff", bus.core_last[23:0]); end
    repeat (4) @(negedge clk);
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    wait_rdy(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL miss_timeout: got rdy=0 expected rdy=1 within 3000 cycles"); end
    repeat (2) @(negedge clk);
    checks++; if (disp_n - d0 != 16) begin errors++; $display("FAIL miss_dispatch_count: got %0d expected 16", disp_n - d0); end
    for (int k = 0; k < 16; k++) begin
      logic [KW-1:0] exp_b;
      exp_b = KW'(k) << CW;
      checks++; if (d_base[d0 + k] !== exp_b) begin errors++; $display("FAIL miss_base_%0d: got %h expected %h", k, d_base[d0 + k], exp_b); end
    end
    checks++; if (d_last[d0 + 15] !== 24'hFFFFFF) begin errors++; $display("FAIL miss_final_last: got %h expected ffffff", d_last[d0 + 15]); end
    checks++; if (d_last[d0 + 7] !== 24'h7FFFFF) begin errors++; $display("FAIL miss_mid_last: got %h expected 7fffff", d_last[d0 + 7]); end
    checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL miss_key_valid: got %b expected 0", bus.key_valid); end
    checks++; if (bus.key_out !== 24'h0) begin errors++; $display("FAIL miss_key_out: got %h expected 000000", bus.key_out); end
    checks++; if (bus.win_core !== 1'b0) begin errors++; $display("FAIL miss_win_core: got %h expected 0", bus.win_core); end
    checks++; if (abort_cnt[0] - a0 + abort_cnt[1] - a1 != 0) begin errors++; $display("FAIL miss_aborts: got %0d expected 0", abort_cnt[0] - a0 + abort_cnt[1] - a1); end
    checks++; if (rdy_cyc - done_cyc != 1) begin errors++; $display("FAIL miss_done_to_rdy: got %0d expected 1", rdy_cyc - done_cyc); end
`ifdef CRACK_SCHED_PERF_EN
    checks++; if (perf_chunks !== 16'd16) begin errors++; $display("FAIL perf_chunks: got %0d expected 16", perf_chunks); end
`endif
  endtask

  task automatic test_early_hit();
    int d0, a0, a1;
    bit ok;
    lat = '{20, 40};
    force_hit = '{1'b1, 1'b0};
    force_key[0] = 24'h0000A5;
    @(negedge clk);
    d0 = disp_n; a0 = abort_cnt[0]; a1 = abort_cnt[1];
    pulse_en();
    wait_rdy(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL early_timeout: got rdy=0 expected rdy=1 within 500 cycles"); end
    repeat (2) @(negedge clk);
    checks++; if (bus.key_valid !== 1'b1) begin errors++; $display("FAIL early_key_valid: got %b expected 1", bus.key_valid); end
    checks++; if (bus.key_out !== 24'h0000A5) begin errors++; $display("FAIL early_key_out: got %h expected 0000a5", bus.key_out); end
    checks++; if (bus.win_core !== 1'b0) begin errors++; $display("FAIL early_win_core: got %h expected 0", bus.win_core); end
    checks++; if (abort_cnt[1] - a1 != 1) begin errors++; $display("FAIL early_abort1: got %0d expected 1", abort_cnt[1] - a1); end
    checks++; if (abort_cnt[0] - a0 != 0) begin errors++; $display("FAIL early_abort0: got %0d expected 0", abort_cnt[0] - a0); end
    checks++; if (disp_n - d0 != 2) begin errors++; $display("FAIL early_dispatches: got %0d expected 2", disp_n - d0); end
    checks++; if (d_base[d0 + 1] !== 24'h100000) begin errors++; $display("FAIL early_base1: got %h expected 100000", d_base[d0 + 1]); end
    checks++; if (rdy_cyc - done_cyc != 2) begin errors++; $display("FAIL early_done_to_rdy: got %0d expected 2", rdy_cyc - done_cyc); end
  endtask

  task automatic test_late_smaller();
    int d0, a0, a1;
    bit ok;
    lat = '{60, 20};
    force_hit = '{1'b1, 1'b1};
    force_key[0] = 24'h000010;
    force_key[1] = 24'h180000;
    @(negedge clk);
    d0 = disp_n; a0 = abort_cnt[0]; a1 = abort_cnt[1];
    pulse_en();
    repeat (30) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL late_mid_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.key_out !== 24'h180000) begin errors++; $display("FAIL late_mid_key: got %h expected 180000", bus.key_out); end
    checks++; if (bus.win_core !== 1'b1) begin errors++; $display("FAIL late_mid_win: got %h expected 1", bus.win_core); end
    wait_rdy(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL late_timeout: got rdy=0 expected rdy=1 within 500 cycles"); end
    repeat (2) @(negedge clk);
    checks++; if (bus.key_out !== 24'h000010) begin errors++; $display("FAIL late_key_out: got %h expected 000010", bus.key_out); end
    checks++; if (bus.win_core !== 1'b0) begin errors++; $display("FAIL late_win_core: got %h expected 0", bus.win_core); end
    checks++; if (bus.key_valid !== 1'b1) begin errors++; $display("FAIL late_key_valid: got %b expected 1", bus.key_valid); end
    checks++; if (abort_cnt[0] - a0 + abort_cnt[1] - a1 != 0) begin errors++; $display("FAIL late_aborts: got %0d expected 0", abort_cnt[0] - a0 + abort_cnt[1] - a1); end
    checks++; if (disp_n - d0 != 2) begin errors++; $display("FAIL late_dispatches: got %0d expected 2", disp_n - d0); end
    checks++; if (rdy_cyc - done_cyc != 1) begin errors++; $display("FAIL late_done_to_rdy: got %0d expected 1", rdy_cyc - done_cyc); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    lat = '{21, 20};
    force_hit = '{1'b1, 1'b1};
    force_key[0] = 24'h300004;
    force_key[1] = 24'h300004;
    pulse_en();
    wait_rdy(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL simA_timeout: got rdy=0 expected rdy=1 within 500 cycles"); end
    checks++; if (bus.key_out !== 24'h300004) begin errors++; $display("FAIL simA_key_out: got %h expected 300004", bus.key_out); end
    checks++; if (bus.win_core !== 1'b0) begin errors++; $display("FAIL simA_win_core: got %h expected 0", bus.win_core); end
    force_key[0] = 24'h500000;
    force_key[1] = 24'h400009;
    pulse_en();
    wait_rdy(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL simB_timeout: got rdy=0 expected rdy=1 within 500 cycles"); end
    checks++; if (bus.key_out !== 24'h400009) begin errors++; $display("FAIL simB_key_out: got %h expected 400009", bus.key_out); end
    checks++; if (bus.win_core !== 1'b1) begin errors++; $display("FAIL simB_win_core: got %h expected 1", bus.win_core); end
    checks++; if (bus.key_valid !== 1'b1) begin errors++; $display("FAIL simB_key_valid: got %b expected 1", bus.key_valid); end
  endtask

  task automatic test_reset_mid_run();
    int d0;
    bit ok;
    lat = '{50, 50};
    force_hit = '{1'b0, 1'b0};
    pulse_en();
    repeat (5) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstrun_busy_before: got %b expected 1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL rstrun_rdy: got %b expected 1", bus.rdy); end
    checks++; if (bus.core_en !== 2'b00) begin errors++; $display("FAIL rstrun_core_en: got %b expected 00", bus.core_en); end
    checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL rstrun_key_valid: got %b expected 0", bus.key_valid); end
    checks++; if (bus.core_abort !== 2'b00) begin errors++; $display("FAIL rstrun_core_abort: got %b expected 00", bus.core_abort); end
    @(negedge clk);
    rst = 1'b0;
    lat = '{10, 50};
    force_hit = '{1'b1, 1'b0};
    force_key[0] = 24'h000005;
    @(negedge clk);
    d0 = disp_n;
    pulse_en();
    checks++; if (bus.core_en !== 2'b01) begin errors++; $display("FAIL rstrun_restart_en: got %b expected 01", bus.core_en); end
    checks++; if (bus.core_base[23:0] !== 24'h000000) begin errors++; $display("FAIL rstrun_restart_base: got %h expected 000000", bus.core_base[23:0]); end
    wait_rdy(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstrun_timeout: got rdy=0 expected rdy=1 within 500 cycles"); end
    repeat (2) @(negedge clk);
    checks++; if (d_base[d0 + 1] !== 24'h100000) begin errors++; $display("FAIL rstrun_second_base: got %h expected 100000", d_base[d0 + 1]); end
    checks++; if (bus.key_out !== 24'h000005) begin errors++; $display("FAIL rstrun_key_out: got %h expected 000005", bus.key_out); end
  endtask

  initial begin
    bus.en = 1'b0;
    lat = '{8, 8};
    force_hit = '{1'b0, 1'b0};
    force_key[0] = '0;
    force_key[1] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_full_miss();
    test_early_hit();
    test_late_smaller();
    test_simultaneous();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
